// File: rtl/decompress_send_data.sv
// decompress_send_data
// Takes one TILE_SIZE x TILE_SIZE tile as four planar byte planes (B, G, R, A)
// and streams it out as interleaved 32-bit BGRA pixels, PPB pixels per beat.
// PPB is 4, 8 or 16, chosen by data_width (128/256/512) when the tile is
// accepted. Both sides use a valid/ready handshake.
//
// Output beats are held in registers. The next beat is formatted one cycle
// ahead, either from the incoming planes on accept or from the tile buffer
// on advance, so o_data is driven straight from a flop.
//
// i_ready is combinational. In SEND it depends on o_ready, so a new tile can
// be taken on the same edge that retires the last beat of the current tile.
// That gives back-to-back tiles with no bubble.
//
// NPIX must be a multiple of 16 so that every supported width divides the tile.

module decompress_send_data #(
    parameter int TILE_SIZE = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [31:0]                          data_width,
    input  logic                                 i_valid,
    output logic                                 i_ready,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0]     b_data,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0]     g_data,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0]     r_data,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0]     a_data,
    output logic                                 o_valid,
    input  logic                                 o_ready,
    output logic [511:0]                         o_data,
    output logic                                 o_last
);

    localparam int NPIX = TILE_SIZE * TILE_SIZE;
    localparam int PW   = 8 * NPIX;
    localparam int CW   = $clog2(NPIX) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Pixels per beat for a given bus width; zero marks an unsupported width.
    function automatic logic [CW-1:0] ppb_of(input logic [31:0] dw);
        logic [CW-1:0] v;
        case (dw)
            32'd128: v = CW'(4);
            32'd256: v = CW'(8);
            32'd512: v = CW'(16);
            default: v = {CW{1'b0}};
        endcase
        return v;
    endfunction

    // Beats per tile for a given bus width; zero for an unsupported width.
    function automatic logic [CW-1:0] nbeat_of(input logic [31:0] dw);
        logic [CW-1:0] v;
        case (dw)
            32'd128: v = CW'(NPIX / 4);
            32'd256: v = CW'(NPIX / 8);
            32'd512: v = CW'(NPIX / 16);
            default: v = {CW{1'b0}};
        endcase
        return v;
    endfunction

    // Build beat k from four planes. Lane j carries pixel k*ppb+j as
    // {A,R,G,B}. Lanes at and above ppb are left zero.
    function automatic logic [511:0] build_beat(
        input logic [PW-1:0] b,
        input logic [PW-1:0] g,
        input logic [PW-1:0] r,
        input logic [PW-1:0] a,
        input logic [CW-1:0] beat,
        input logic [CW-1:0] ppb
    );
        logic [511:0] v;
        int           p;
        v = 512'd0;
        for (int j = 0; j < 16; j++) begin
            p = int'(beat) * int'(ppb) + j;
            if ((j < int'(ppb)) && (p < NPIX)) begin
                v[32*j +: 32] = {a[8*p +: 8], r[8*p +: 8], g[8*p +: 8], b[8*p +: 8]};
            end else begin
                v[32*j +: 32] = 32'h0000_0000;
            end
        end
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   ppb_q, ppb_d;
    logic [CW-1:0]   nbeat_q, nbeat_d;
    logic [PW-1:0]   b_q, b_d;
    logic [PW-1:0]   g_q, g_d;
    logic [PW-1:0]   r_q, r_d;
    logic [PW-1:0]   a_q, a_d;
    logic            o_valid_q, o_valid_d;
    logic            o_last_q, o_last_d;
    logic [511:0]    o_data_q, o_data_d;

    logic [CW-1:0]   ppb_s;
    logic [CW-1:0]   nbeat_s;
    logic            width_ok_s;
    logic            last_s;
    logic            hs_s;
    logic            i_ready_s;
    logic            accept_s;
    logic [CW-1:0]   beat_inc_s;

    // Decode width, compute handshakes, and choose the next FSM state.
    always_comb begin
        ppb_s      = ppb_of(data_width);
        nbeat_s    = nbeat_of(data_width);
        width_ok_s = (ppb_s != {CW{1'b0}});
        last_s     = (beat_q == (nbeat_q - CW'(1)));
        hs_s       = o_valid_q && o_ready;
        i_ready_s  = 1'b0;
        state_d    = state_q;
        case (state_q)
            ST_IDLE: begin
                i_ready_s = width_ok_s;
                if (i_valid && width_ok_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Ready for the next tile only when the last beat retires this cycle.
                i_ready_s = o_ready && last_s && width_ok_s;
                if (hs_s && last_s) begin
                    if (i_valid && i_ready_s) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                i_ready_s = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        accept_s = i_valid && i_ready_s;
    end

    // Next values for the tile buffer, beat counter and registered outputs.
    always_comb begin
        b_d        = b_q;
        g_d        = g_q;
        r_d        = r_q;
        a_d        = a_q;
        ppb_d      = ppb_q;
        nbeat_d    = nbeat_q;
        beat_d     = beat_q;
        o_valid_d  = o_valid_q;
        o_last_d   = o_last_q;
        o_data_d   = o_data_q;
        beat_inc_s = beat_q + CW'(1);
        if (accept_s) begin
            // New tile: capture planes and width, then present beat 0 next cycle.
            b_d       = b_data;
            g_d       = g_data;
            r_d       = r_data;
            a_d       = a_data;
            ppb_d     = ppb_s;
            nbeat_d   = nbeat_s;
            beat_d    = {CW{1'b0}};
            o_valid_d = 1'b1;
            o_last_d  = (nbeat_s == CW'(1));
            o_data_d  = build_beat(b_data, g_data, r_data, a_data, {CW{1'b0}}, ppb_s);
        end else if (hs_s && !last_s) begin
            // Beat taken: advance to the next beat of the buffered tile.
            beat_d    = beat_inc_s;
            o_valid_d = 1'b1;
            o_last_d  = (beat_inc_s == (nbeat_q - CW'(1)));
            o_data_d  = build_beat(b_q, g_q, r_q, a_q, beat_inc_s, ppb_q);
        end else if (hs_s) begin
            // Last beat taken and no follow-on tile: bus goes quiet.
            beat_d    = {CW{1'b0}};
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            o_data_d  = 512'd0;
        end else begin
            // Idle or stalled: everything holds.
            beat_d    = beat_q;
        end
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any tile that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q       <= {PW{1'b0}};
            g_q       <= {PW{1'b0}};
            r_q       <= {PW{1'b0}};
            a_q       <= {PW{1'b0}};
            ppb_q     <= {CW{1'b0}};
            nbeat_q   <= {CW{1'b0}};
            beat_q    <= {CW{1'b0}};
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= 512'd0;
        end else begin
            b_q       <= b_d;
            g_q       <= g_d;
            r_q       <= r_d;
            a_q       <= a_d;
            ppb_q     <= ppb_d;
            nbeat_q   <= nbeat_d;
            beat_q    <= beat_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
        end
    end

    assign i_ready = i_ready_s;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_decompress_send_data.sv
// Testbench for decompress_send_data. Expected beats are computed from the
// planes when each tile is driven and pushed into a queue. A monitor records
// every beat that crosses the output handshake. Each test then compares the
// two queues and adds its own checks on timing and ready.

module tb_decompress_send_data;

    localparam int NPIX = 64;

    typedef struct packed {
        logic [511:0] d;
        logic         l;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [31:0]   data_width;
    logic          i_valid;
    logic          i_ready;
    logic [511:0]  b_v, g_v, r_v, a_v;
    logic          o_valid;
    logic          o_ready;
    logic [511:0]  o_data;
    logic          o_last;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    n_cmp;
    int    n_fail;

    decompress_send_data #(.TILE_SIZE(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_width (data_width),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .b_data     (b_v),
        .g_data     (g_v),
        .r_data     (r_v),
        .a_data     (a_v),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_last     (o_last)
    );

    always #5 clk = ~clk;

    // Record every beat the DUT hands over (sampled mid-cycle).
    always @(negedge clk) begin
        if (rst_n && o_valid && o_ready) begin
            obs_q.push_back('{d: o_data, l: o_last});
        end
    end

    task automatic set_planes(input int seed);
        for (int p = 0; p < NPIX; p++) begin
            b_v[8*p +: 8] = 8'(p + seed);
            g_v[8*p +: 8] = 8'(8'h40 + p + seed);
            r_v[8*p +: 8] = 8'(8'h80 + p + seed);
            a_v[8*p +: 8] = 8'(8'hC0 + p + seed);
        end
    endtask

    // Reference model: push every expected beat of the current planes at the given width.
    task automatic push_exp(input int width);
        int    ppb;
        int    nbeat;
        int    p;
        beat_t e;
        ppb   = width / 32;
        nbeat = NPIX / ppb;
        for (int k = 0; k < nbeat; k++) begin
            e.d = '0;
            for (int j = 0; j < ppb; j++) begin
                p = k * ppb + j;
                e.d[32*j +: 32] = {a_v[8*p +: 8], r_v[8*p +: 8], g_v[8*p +: 8], b_v[8*p +: 8]};
            end
            e.l = (k == nbeat - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
        n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_o_last got %b want 0", o_last); end
        n_cmp++; if (o_data !== 512'd0) begin n_fail++; $display("FAIL reset_o_data got %h want 0", o_data); end
        n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready got %b want 1", i_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_width512;
        logic [511:0] rb, rg, rr, ra;
        int p;
        exp_q.delete(); obs_q.delete();
        o_ready = 1'b1; set_planes(0);
        @(posedge clk); #1;
        data_width = 32'd512; i_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL w512_i_ready got %b want 1", i_ready); end
        push_exp(512);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL w512_latency o_valid got %b want 1", o_valid); end
        repeat (8) @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL w512_idle o_valid got %b want 0", o_valid); end
        n_cmp++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL w512_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL w512_beat%0d got %h last %b want %h last %b", i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        if (obs_q.size() == 4) begin
            n_cmp++; if (obs_q[0].d[31:0] !== 32'hC080_4000) begin n_fail++; $display("FAIL w512_b0_lo got %h want c0804000", obs_q[0].d[31:0]); end
            n_cmp++; if (obs_q[0].d[511:480] !== 32'hCF8F_4F0F) begin n_fail++; $display("FAIL w512_b0_hi got %h want cf8f4f0f", obs_q[0].d[511:480]); end
            // Receiver-side reconstruction of the four planes from the beats.
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 16; j++) begin
                    p = k * 16 + j;
                    rb[8*p +: 8] = obs_q[k].d[32*j +: 8];
                    rg[8*p +: 8] = obs_q[k].d[32*j+8 +: 8];
                    rr[8*p +: 8] = obs_q[k].d[32*j+16 +: 8];
                    ra[8*p +: 8] = obs_q[k].d[32*j+24 +: 8];
                end
            end
            n_cmp++;
            if ({rb, rg, rr, ra} !== {b_v, g_v, r_v, a_v}) begin
                n_fail++; $display("FAIL w512_roundtrip got b=%h want b=%h", rb, b_v);
            end
        end
    endtask

    task automatic test_width128;
        exp_q.delete(); obs_q.delete();
        o_ready = 1'b1; set_planes(0);
        @(posedge clk); #1;
        data_width = 32'd128; i_valid = 1'b1;
        @(negedge clk);
        push_exp(128);
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL w128_count got %0d want 16", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL w128_beat%0d got %h last %b want %h last %b", i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
            end
            n_cmp++;
            if (obs_q[i].d[511:128] !== 384'd0) begin n_fail++; $display("FAIL w128_upper%0d got %h want 0", i, obs_q[i].d[511:128]); end
        end
        if (obs_q.size() == 16) begin
            n_cmp++;
            if ({obs_q[15].d[127:96], obs_q[15].l} !== {32'hFFBF_7F3F, 1'b1}) begin
                n_fail++; $display("FAIL w128_b15 got %h last %b want ffbf7f3f last 1", obs_q[15].d[127:96], obs_q[15].l);
            end
        end
    endtask

    task automatic test_stall256;
        logic [3:0]   pat;
        logic [511:0] prev_d;
        logic         prev_l, prev_stall;
        exp_q.delete(); obs_q.delete();
        pat = 4'b1001; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        o_ready = 1'b1; set_planes(7);
        @(posedge clk); #1;
        data_width = 32'd256; i_valid = 1'b1;
        @(negedge clk);
        push_exp(256);
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            o_ready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if ({o_valid, o_data, o_last} !== {1'b1, prev_d, prev_l}) begin
                    n_fail++; $display("FAIL stall_hold cyc %0d got %h last %b want %h last %b", c, o_data, o_last, prev_d, prev_l);
                end
            end
            prev_stall = o_valid && !o_ready;
            prev_d = o_data; prev_l = o_last;
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        n_cmp++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL stall_count got %0d want 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_beat%0d got %h last %b want %h last %b", i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_q.delete(); obs_q.delete();
        o_ready = 1'b1; set_planes(8'h11);
        @(posedge clk); #1;
        data_width = 32'd512; i_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready got %b want 1", i_ready); end
        push_exp(512);
        @(posedge clk); #1;
        set_planes(8'h55);
        push_exp(512);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid cyc %0d got %b want 1", k, o_valid); end
            n_cmp++;
            if (i_ready !== ((k % 4) == 3)) begin
                n_fail++; $display("FAIL b2b_i_ready cyc %0d got %b want %b", k, i_ready, ((k % 4) == 3));
            end
            if (k == 3) begin
                @(posedge clk); #1;
                i_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b want 0", o_valid); end
        repeat (2) @(negedge clk);
        n_cmp++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d got %h last %b want %h last %b", i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
    endtask

    task automatic test_bad_width;
        exp_q.delete(); obs_q.delete();
        o_ready = 1'b1; set_planes(8'h23);
        @(posedge clk); #1;
        data_width = 32'd100; i_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({i_ready, o_valid} !== 2'b00) begin
                n_fail++; $display("FAIL badw_blocked cyc %0d got i_ready %b o_valid %b want 0 0", c, i_ready, o_valid);
            end
        end
        @(posedge clk); #1;
        data_width = 32'd256;
        @(negedge clk);
        n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL badw_ready256 got %b want 1", i_ready); end
        push_exp(256);
        @(posedge clk); #1;
        i_valid = 1'b0;
        data_width = 32'd100;  // a mid-tile width change must not affect this tile
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL badw_latency got %b want 1", o_valid); end
        repeat (12) @(negedge clk);
        n_cmp++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL badw_count got %0d want 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL badw_beat%0d got %h last %b want %h last %b", i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_q.delete(); obs_q.delete();
        o_ready = 1'b1; set_planes(8'h31);
        @(posedge clk); #1;
        data_width = 32'd128; i_valid = 1'b1;
        @(negedge clk);
        push_exp(128);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);  // beat 0
        @(negedge clk);  // beat 1
        @(posedge clk); #1;
        rst_n = 1'b0;    // beat 2 is on the bus; reset at the next edge
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_valid, o_last, i_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rstmid_ctrl got v%b l%b r%b want v0 l0 r1", o_valid, o_last, i_ready);
        end
        n_cmp++; if (o_data !== 512'd0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", o_data); end
        n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL rstmid_count got %0d want 2", obs_q.size()); end
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_beat%0d got %h want %h", i, obs_q[i].d, exp_q[i].d);
            end
        end
        // Following tile must start from beat 0.
        exp_q.delete(); obs_q.delete();
        set_planes(8'h70);
        @(posedge clk); #1;
        i_valid = 1'b1;
        @(negedge clk);
        push_exp(128);
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL rstmid_next_count got %0d want 16", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_next_beat%0d got %h want %h", i, obs_q[i].d, exp_q[i].d);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; data_width = 32'd512;
        i_valid = 1'b0; o_ready = 1'b0;
        b_v = '0; g_v = '0; r_v = '0; a_v = '0;
        n_cmp = 0; n_fail = 0;
        test_reset;
        test_width512;
        test_width128;
        test_stall256;
        test_back_to_back;
        test_bad_width;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
